// File: rtl/inst_memory_block.sv
// -----------------------------------------------------------------------------
// inst_memory_block
//
// This is the backing instruction memory that sits behind the instruction
// cache. It holds 1024 bytes, which is 256 32-bit instructions. On a cache miss
// it returns one 16-byte block (four instructions). The data arrives LATENCY
// clock cycles after the request is accepted, using the cache's READ/BUSYWAIT
// handshake. A byte-wide program-load port fills the memory while no block
// read is in flight.
//
// Ports
//   CLK        in   1    system clock, all state changes on posedge
//   RESET      in   1    asynchronous active-low reset
//   READ       in   1    block read request from the instruction cache
//   ADDRESS    in   6    block address (PC[9:4]), base byte = {ADDRESS,4'b0}
//   READDATA   out  128  fetched block, byte k at bits [8k+7:8k]
//   BUSYWAIT   out  1    high while a block read is in progress
//   PROG_WE    in   1    program-load byte write enable
//   PROG_ADDR  in   10   program-load byte address
//   PROG_DATA  in   8    program-load byte data
// -----------------------------------------------------------------------------
module inst_memory_block #(
  parameter int LATENCY   = 40,   // BUSYWAIT high cycles per block read, 1..255
  parameter int MEM_BYTES = 1024  // fixed: ADDRESS/PROG_ADDR widths assume it
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic [5:0]   ADDRESS,
  output logic [127:0] READDATA,
  output logic         BUSYWAIT,
  input  logic         PROG_WE,
  input  logic [9:0]   PROG_ADDR,
  input  logic [7:0]   PROG_DATA
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [7:0]   count_q, count_d;
  logic [5:0]   addr_q, addr_d;
  logic [127:0] readdata_q, readdata_d;
  logic         busywait_q, busywait_d;

  logic [7:0]   mem [0:MEM_BYTES-1];
  logic [127:0] block_data;
  logic         prog_en;

  // Program-load writes are blocked only while a read is in flight. That way
  // the block being fetched cannot change under the cache.
  assign prog_en = PROG_WE && (state_q != BUSY);

  // Reset does not touch the storage. A program loaded before a reset
  // survives it.
  always_ff @(posedge CLK) begin
    if (prog_en) begin
      mem[PROG_ADDR] <= PROG_DATA;
    end
  end

  // Gather the 16 bytes of the latched block. Byte k goes to lane k.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_block_bytes
      assign block_data[8*gi +: 8] = mem[{addr_q, 4'(gi)}];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    readdata_d = readdata_q;
    busywait_d = busywait_q;
    case (state_q)
      IDLE: begin
        // PROG_WE wins the edge. The cache keeps READ asserted, so the request
        // is accepted on a later edge.
        if (READ && !PROG_WE) begin
          addr_d     = ADDRESS;
          count_d    = 8'd1;
          busywait_d = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // The counter is 1 on the accepting edge. The completing edge therefore
        // comes exactly LATENCY cycles later. READDATA and BUSYWAIT update
        // together, so the data is stable when BUSYWAIT falls.
        if (count_q >= 8'(LATENCY)) begin
          readdata_d = block_data;
          busywait_d = 1'b0;
          state_d    = DONE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      DONE: begin
        // READ is ignored for one cycle. A READ still held from the miss that
        // just completed cannot start a duplicate fetch.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      addr_q     <= 6'd0;
      readdata_q <= 128'h0;
      busywait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      readdata_q <= readdata_d;
      busywait_q <= busywait_d;
    end
  end

  assign READDATA = readdata_q;
  assign BUSYWAIT = busywait_q;

endmodule

// File: tb/tb_inst_memory_block.sv
// -----------------------------------------------------------------------------
// tb_inst_memory_block
//
// Directed bench for inst_memory_block with LATENCY=40. Inputs change on the
// falling clock edge. Outputs are sampled on the falling edge or 1 time unit
// after an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_inst_memory_block;

  localparam int LAT = 40;

  localparam logic [127:0] BLK1_INIT  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] BLK1_PATCH = 128'h0F0E0D0C0B0A090807065A0403020100;
  localparam logic [127:0] BLK63      = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0;
  logic [5:0]   ADDRESS = 6'd0;
  logic [127:0] READDATA;
  logic         BUSYWAIT;
  logic         PROG_WE = 1'b0;
  logic [9:0]   PROG_ADDR = 10'd0;
  logic [7:0]   PROG_DATA = 8'd0;

  int pass_cnt = 0;
  int total_cnt = 0;

  inst_memory_block #(.LATENCY(LAT), .MEM_BYTES(1024)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .ADDRESS(ADDRESS),
    .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
    .PROG_WE(PROG_WE),
    .PROG_ADDR(PROG_ADDR),
    .PROG_DATA(PROG_DATA)
  );

  always #5 CLK = ~CLK;

  // Writes one byte through the program-load port. Called from IDLE only.
  task automatic prog_byte(input logic [9:0] a, input logic [7:0] d);
    @(negedge CLK);
    PROG_WE = 1'b1; PROG_ADDR = a; PROG_DATA = d;
    @(negedge CLK);
    PROG_WE = 1'b0;
  endtask

  // Stimulus only. It raises READ and drops it after the accepting edge.
  // It returns the BUSYWAIT-high cycle count and the data seen at the fall,
  // and leaves the DUT back in IDLE.
  task automatic run_fetch(input logic [5:0] a, output int cycles, output logic [127:0] data);
    @(negedge CLK);
    READ = 1'b1; ADDRESS = a;
    @(negedge CLK);
    READ = 1'b0;
    cycles = 0;
    while (BUSYWAIT === 1'b1 && cycles < 300) begin
      cycles++;
      @(negedge CLK);
    end
    data = READDATA;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    logic stayed_idle;
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    total_cnt++;
    if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT);
    else pass_cnt++;
    RESET = 1'b1;
    stayed_idle = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (BUSYWAIT !== 1'b0) stayed_idle = 1'b0;
    end
    total_cnt++;
    if (stayed_idle !== 1'b1) $display("FAIL idle_no_read: BUSYWAIT rose with READ=0");
    else pass_cnt++;
    total_cnt++;
    if (READDATA !== 128'h0) $display("FAIL reset_readdata: got %h expected 0", READDATA);
    else pass_cnt++;
    $display("reset/idle: BUSYWAIT=%b READDATA=%h", BUSYWAIT, READDATA);
  endtask

  task automatic test_single_fetch;
    int cyc;
    logic [127:0] d;
    for (int i = 0; i < 16; i++) prog_byte(10'h010 + 10'(i), 8'(i));
    run_fetch(6'd1, cyc, d);
    total_cnt++;
    if (cyc !== LAT) $display("FAIL single_latency: got %0d cycles expected %0d", cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (d !== BLK1_INIT) $display("FAIL single_data: got %h expected %h", d, BLK1_INIT);
    else pass_cnt++;
    total_cnt++;
    if (BUSYWAIT !== 1'b0) $display("FAIL single_idle_after: BUSYWAIT=%b expected 0", BUSYWAIT);
    else pass_cnt++;
    $display("single fetch blk1: cycles=%0d data=%h", cyc, d);
  endtask

  // While READ is held, the DUT goes accept -> 40 BUSY cycles -> DONE -> IDLE
  // -> accept. Consecutive BUSYWAIT rises are therefore LAT+2 cycles apart.
  task automatic test_sticky_read;
    int c, nrise, nfall;
    int rise_at [3];
    logic prev;
    for (int i = 0; i < 16; i++) prog_byte(10'h3F0 + 10'(i), 8'hA0 + 8'(i));
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'd63;
    prev = 1'b0; c = 0; nrise = 0; nfall = 0;
    while (nfall < 3 && c < 400) begin
      @(negedge CLK);
      c++;
      if (BUSYWAIT === 1'b1 && prev === 1'b0) begin
        if (nrise < 3) rise_at[nrise] = c;
        nrise++;
      end
      if (BUSYWAIT === 1'b0 && prev === 1'b1) begin
        total_cnt++;
        if (c - rise_at[nfall] !== LAT)
          $display("FAIL sticky_width%0d: got %0d expected %0d", nfall, c - rise_at[nfall], LAT);
        else pass_cnt++;
        total_cnt++;
        if (READDATA !== BLK63)
          $display("FAIL sticky_data%0d: got %h expected %h", nfall, READDATA, BLK63);
        else pass_cnt++;
        $display("sticky fetch %0d: rise=%0d fall=%0d data=%h", nfall, rise_at[nfall], c, READDATA);
        nfall++;
      end
      prev = BUSYWAIT;
    end
    READ = 1'b0;
    repeat (2) @(negedge CLK);
    total_cnt++;
    if (nfall !== 3 || nrise !== 3)
      $display("FAIL sticky_count: rises=%0d falls=%0d expected 3/3", nrise, nfall);
    else pass_cnt++;
    total_cnt++;
    if (rise_at[1] - rise_at[0] !== LAT + 2)
      $display("FAIL sticky_spacing01: got %0d expected %0d", rise_at[1] - rise_at[0], LAT + 2);
    else pass_cnt++;
    total_cnt++;
    if (rise_at[2] - rise_at[1] !== LAT + 2)
      $display("FAIL sticky_spacing12: got %0d expected %0d", rise_at[2] - rise_at[1], LAT + 2);
    else pass_cnt++;
  endtask

  task automatic test_mid_read;
    int cyc;
    logic [127:0] d;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'd1;
    @(negedge CLK);
    // The read is in flight. Disturb every input; none of it may take effect.
    READ = 1'b0; ADDRESS = 6'd5;
    PROG_WE = 1'b1; PROG_ADDR = 10'h014; PROG_DATA = 8'hEE;
    @(negedge CLK);
    PROG_WE = 1'b0;
    cyc = 1;
    while (BUSYWAIT === 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge CLK);
    end
    d = READDATA;
    total_cnt++;
    if (cyc !== LAT) $display("FAIL mid_latency: got %0d expected %0d", cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (d !== BLK1_INIT) $display("FAIL mid_data: got %h expected %h", d, BLK1_INIT);
    else pass_cnt++;
    $display("mid-read disturbance: cycles=%0d data=%h", cyc, d);
    @(negedge CLK);
    run_fetch(6'd1, cyc, d);
    total_cnt++;
    if (d[39:32] !== 8'h04) $display("FAIL mid_no_write: byte 0x014 got %h expected 04", d[39:32]);
    else pass_cnt++;
    $display("refetch blk1: data=%h", d);
  endtask

  task automatic test_priority;
    int cyc;
    logic [127:0] d;
    @(negedge CLK);
    PROG_WE = 1'b1; PROG_ADDR = 10'h015; PROG_DATA = 8'h5A;
    READ = 1'b1; ADDRESS = 6'd1;
    @(negedge CLK);
    PROG_WE = 1'b0;
    total_cnt++;
    if (BUSYWAIT !== 1'b0) $display("FAIL prio_write_edge: BUSYWAIT=%b expected 0", BUSYWAIT);
    else pass_cnt++;
    @(negedge CLK);
    READ = 1'b0;
    total_cnt++;
    if (BUSYWAIT !== 1'b1) $display("FAIL prio_accept_edge: BUSYWAIT=%b expected 1", BUSYWAIT);
    else pass_cnt++;
    cyc = 0;
    while (BUSYWAIT === 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge CLK);
    end
    d = READDATA;
    total_cnt++;
    if (d !== BLK1_PATCH) $display("FAIL prio_data: got %h expected %h", d, BLK1_PATCH);
    else pass_cnt++;
    $display("write/read priority: cycles=%0d data=%h", cyc, d);
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [127:0] d;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'd1;
    @(negedge CLK);
    READ = 1'b0;
    repeat (19) @(negedge CLK);
    // 20 BUSY cycles have elapsed. Assert reset between clock edges.
    RESET = 1'b0;
    #1;
    total_cnt++;
    if (BUSYWAIT !== 1'b0) $display("FAIL rstmid_busywait: got %b expected 0", BUSYWAIT);
    else pass_cnt++;
    total_cnt++;
    if (READDATA !== 128'h0) $display("FAIL rstmid_readdata: got %h expected 0", READDATA);
    else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b1;
    run_fetch(6'd1, cyc, d);
    total_cnt++;
    if (cyc !== LAT) $display("FAIL rstmid_relatency: got %0d expected %0d", cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (d !== BLK1_PATCH) $display("FAIL rstmid_redata: got %h expected %h", d, BLK1_PATCH);
    else pass_cnt++;
    $display("reset mid-read then refetch: cycles=%0d data=%h", cyc, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_sticky_read();
    test_mid_read();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
